// File: rtl/uart_io_pkg.sv
// uart_io shared definitions: register offsets, STATUS bit positions, FSM states.
// Optional feature macro UART_IO_RX_FIFO_EN is consumed by uart_io.
package uart_io_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIVL   = 2'd2;
   localparam logic [1:0] OFF_DIVH   = 2'd3;

   localparam int ST_RXV  = 0;
   localparam int ST_TXR  = 1;
   localparam int ST_OVR  = 2;
   localparam int ST_IE   = 3;
   localparam int ST_FERR = 4;

   typedef enum logic [1:0] {
      TX_IDLE, TX_START, TX_DATA, TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_io_fifo.sv
// uart_io receive store: DEPTH-entry FIFO, push accepted when full only
// if a pop happens in the same cycle.
module uart_io_fifo
   import uart_io_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          do_pop;
   logic          do_push;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop)
            rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/uart_io.sv
// Memory-mapped UART: DATA/STATUS/DIVL/DIVH window at BASE_ADDR.
// Define UART_IO_RX_FIFO_EN for a 4-entry RX FIFO (default: 1 byte).
module uart_io
   import uart_io_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hFF00,
   parameter logic [15:0] DIV_RESET = 16'd103
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic [15:0] address,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        sel,
   input  logic        rxd,
   output logic        txd,
   output logic        irq
);

`ifdef UART_IO_RX_FIFO_EN
   localparam int RX_DEPTH = 4;
`else
   localparam int RX_DEPTH = 1;
`endif

   logic [1:0]  off;
   logic        wr;
   logic        wr_data;
   logic        wr_status;
   logic [15:0] div;
   logic        ie;
   logic        ovr;
   logic        ferr;
   logic [7:0]  hold;
   logic        hold_full;
   logic        tx_ready;

   tx_state_t   tx_state;
   tx_state_t   tx_next;
   logic [15:0] tx_cnt;
   logic [15:0] tx_div;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_sh;
   logic        tx_tick;
   logic        tx_load;

   rx_state_t   rx_state;
   rx_state_t   rx_next;
   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;
   logic [15:0] rx_cnt;
   logic [15:0] rx_div;
   logic [16:0] rx_half;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_sh;
   logic        rx_sample;
   logic        rx_push;
   logic        rx_ferr;
   logic        rx_pop;
   logic        rx_empty;
   logic        rx_full;
   logic        rx_valid;
   logic [7:0]  rx_dout;

   assign sel       = (address[15:2] == BASE_ADDR[15:2]);
   assign off       = address[1:0];
   assign wr        = sel & ~read;
   assign wr_data   = wr & (off == OFF_DATA);
   assign wr_status = wr & (off == OFF_STATUS);
   assign tx_ready  = ~hold_full;
   assign rx_valid  = ~rx_empty;
   assign rx_pop    = wr_status & wdata[ST_RXV];
   assign irq       = rx_valid | (tx_ready & ie);

   always_comb begin
      rdata = '0;
      case (off)
         OFF_DATA:   rdata = rx_dout;
         OFF_STATUS: rdata = {3'b000, ferr, ie, ovr, tx_ready, rx_valid};
         OFF_DIVL:   rdata = div[7:0];
         OFF_DIVH:   rdata = div[15:8];
         default:    rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div  <= DIV_RESET;
         ie   <= 1'b0;
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         if (wr & (off == OFF_DIVL)) div[7:0]  <= wdata;
         if (wr & (off == OFF_DIVH)) div[15:8] <= wdata;
         if (wr_status) begin
            ie <= wdata[ST_IE];
            if (wdata[ST_OVR])  ovr  <= 1'b0;
            if (wdata[ST_FERR]) ferr <= 1'b0;
         end
         if (rx_push & rx_full & ~(rx_pop & ~rx_empty)) ovr <= 1'b1;
         if (rx_ferr) ferr <= 1'b1;
      end
   end

   always_comb begin
      tx_next = tx_state;
      tx_tick = (tx_cnt == tx_div);
      unique case (tx_state)
         TX_IDLE:  if (hold_full) tx_next = TX_START;
         TX_START: if (tx_tick) tx_next = TX_DATA;
         TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_tick) tx_next = hold_full ? TX_START : TX_IDLE;
      endcase
      tx_load = (tx_next == TX_START) && (tx_state != TX_START);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state  <= TX_IDLE;
         tx_cnt    <= '0;
         tx_div    <= DIV_RESET;
         tx_bit    <= '0;
         tx_sh     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         tx_state <= tx_next;
         tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 16'd1;
         if (tx_state == TX_IDLE || tx_tick) tx_div <= div;
         if (tx_state == TX_DATA && tx_tick) begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 3'd1;
         end
         if (tx_load) begin
            tx_sh     <= hold;
            tx_bit    <= '0;
            hold_full <= 1'b0;
         end else if (wr_data && !hold_full) begin
            hold      <= wdata;
            hold_full <= 1'b1;
         end
      end
   end

   assign txd = (tx_state == TX_START) ? 1'b0 :
                (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;

   // +2 offsets the synchronizer and edge-detect delay so sampling lands mid-bit
   assign rx_half = ({1'b0, rx_div} + 17'd1) >> 1;

   always_comb begin
      rx_next   = rx_state;
      rx_sample = 1'b0;
      rx_push   = 1'b0;
      rx_ferr   = 1'b0;
      unique case (rx_state)
         RX_IDLE:  if (rx_prev & ~rx_s2) rx_next = RX_START;
         RX_START: if ({1'b0, rx_cnt} + 17'd2 >= rx_half) begin
            rx_sample = 1'b1;
            rx_next   = rx_s2 ? RX_IDLE : RX_DATA;
         end
         RX_DATA:  if (rx_cnt == rx_div) begin
            rx_sample = 1'b1;
            if (rx_bit == 3'd7) rx_next = RX_STOP;
         end
         RX_STOP:  if (rx_cnt == rx_div) begin
            rx_sample = 1'b1;
            rx_next   = RX_IDLE;
            rx_push   = rx_s2;
            rx_ferr   = ~rx_s2;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= DIV_RESET;
         rx_bit   <= '0;
         rx_sh    <= '0;
      end else begin
         rx_s1    <= rxd;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_next;
         rx_cnt   <= (rx_state == RX_IDLE || rx_sample) ? '0 : rx_cnt + 16'd1;
         if (rx_state == RX_IDLE || rx_sample) rx_div <= div;
         if (rx_state == RX_START) rx_bit <= '0;
         if (rx_state == RX_DATA && rx_sample) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
         end
      end
   end

   uart_io_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_sh),
      .dout  (rx_dout),
      .empty (rx_empty),
      .full  (rx_full)
   );

endmodule

// File: tb/tb_uart_io.sv
// Self-checking bench for uart_io: frame-level TX/RX model plus directed cases.
// Honours UART_IO_RX_FIFO_EN for the expected RX store depth.
module tb_uart_io;

`ifdef UART_IO_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   localparam logic [15:0] A_DATA = 16'hFF00;
   localparam logic [15:0] A_STAT = 16'hFF01;
   localparam logic [15:0] A_DIVL = 16'hFF02;
   localparam logic [15:0] A_DIVH = 16'hFF03;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  rdata;
   logic        sel;
   logic        rxd = 1'b1;
   logic        txd;
   logic        irq;

   int checks = 0;
   int failures = 0;

   logic       txq [$];
   logic [7:0] rxq [$];
   logic       m_ovr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_ie = 1'b0;
   int         div_m = 103;

   uart_io dut (
      .clk     (clk),
      .rst     (rst),
      .read    (read),
      .address (address),
      .wdata   (wdata),
      .rdata   (rdata),
      .sel     (sel),
      .rxd     (rxd),
      .txd     (txd),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   task automatic check8(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      logic e;
      #1;
      e = (txq.size() > 0) ? txq.pop_front() : 1'b1;
      check1("txd", txd, e);
   end

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      read = 1'b0; address = a; wdata = d;
      @(negedge clk);
      read = 1'b1; address = 16'h0000;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d,
                           output logic s);
      @(negedge clk);
      read = 1'b1; address = a;
      #1;
      d = rdata; s = sel;
      address = 16'h0000;
   endtask

   task automatic tx_expect(input logic [7:0] b);
      int p = div_m + 1;
      if (txq.size() == 0) txq.push_back(1'b1);
      repeat (p) txq.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (p) txq.push_back(b[i]);
      repeat (p) txq.push_back(1'b1);
   endtask

   task automatic tx_write(input logic [7:0] b);
      @(negedge clk);
      tx_expect(b);
      read = 1'b0; address = A_DATA; wdata = b;
      @(negedge clk);
      read = 1'b1; address = 16'h0000;
   endtask

   task automatic hold_rx(input logic v, input int n);
      rxd = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic rx_model(input logic [7:0] b, input logic stop);
      if (!stop) m_ferr = 1'b1;
      else if (rxq.size() < DEPTH) rxq.push_back(b);
      else m_ovr = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      int p = div_m + 1;
      @(negedge clk);
      hold_rx(1'b0, p);
      for (int i = 0; i < 8; i++) hold_rx(b[i], p);
      hold_rx(stop, p);
      rxd = 1'b1;
      repeat (2 * p) @(negedge clk);
      rx_model(b, stop);
   endtask

   function automatic logic [7:0] exp_status();
      return {3'b000, m_ferr, m_ie, m_ovr, 1'b1, rxq.size() != 0};
   endfunction

   task automatic chk_status(input string name);
      logic [7:0] d; logic s;
      bus_read(A_STAT, d, s);
      check8(name, d, exp_status());
   endtask

   task automatic chk_head(input string name);
      logic [7:0] d; logic s;
      bus_read(A_DATA, d, s);
      check8(name, d, (rxq.size() != 0) ? rxq[0] : d);
   endtask

   task automatic rx_pop();
      bus_write(A_STAT, {4'b0000, m_ie, 3'b001});
      if (rxq.size() != 0) void'(rxq.pop_front());
   endtask

   task automatic set_div3();
      bus_write(A_DIVL, 8'h03);
      bus_write(A_DIVH, 8'h00);
      div_m = 3;
   endtask

   task automatic do_reset();
      rxd = 1'b1;
      rst = 1'b1;
      txq.delete();
      rxq.delete();
      m_ovr = 1'b0; m_ferr = 1'b0; m_ie = 1'b0; div_m = 103;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic s;
      logic lit [10];
      logic [7:0] bytes [5];
      lit = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      bus_read(A_STAT, d, s);
      check8("reset_status", d, 8'h02);
      check1("sel_in_window", s, 1'b1);
      bus_read(A_DIVL, d, s);
      check8("reset_divl", d, 8'h67);
      bus_read(A_DIVH, d, s);
      check8("reset_divh", d, 8'h00);
      check1("reset_irq", irq, 1'b0);

      set_div3();
      @(negedge clk);
      tx_expect(8'hA5);
      for (int k = 0; k < 10; k++) check1("model_a5_level", txq[1 + 4 * k], lit[k]);
      read = 1'b0; address = A_DATA; wdata = 8'hA5;
      @(negedge clk);
      read = 1'b1; address = A_STAT;
      #1;
      check8("tx_ready_low_before_start", rdata, 8'h00);
      address = 16'h0000;
      tx_write(8'h5A);
      bus_write(A_DATA, 8'hFF);
      bus_read(A_STAT, d, s);
      check8("hold_full_status", d, 8'h00);
      repeat (100) @(negedge clk);
      check1("tx_queue_drained", txq.size() == 0, 1'b1);

      send_frame(8'h3C, 1'b1);
      chk_status("rx_status_after_3c");
      bus_read(A_DATA, d, s);
      check8("rx_data_3c", d, 8'h3C);
      check1("irq_rx_valid", irq, 1'b1);
      rx_pop();
      chk_status("status_after_pop");
      check1("irq_after_pop", irq, 1'b0);
      rx_pop();
      chk_status("pop_empty_ignored");

      bus_write(A_STAT, 8'h08);
      m_ie = 1'b1;
      @(negedge clk);
      check1("irq_ie_txready", irq, 1'b1);
      chk_status("status_ie");
      bus_write(A_STAT, 8'h00);
      m_ie = 1'b0;
      @(negedge clk);
      check1("irq_ie_off", irq, 1'b0);

      for (int i = 0; i <= DEPTH; i++) send_frame(bytes[i], 1'b1);
      chk_status("status_overflow");
      check1("model_ovr", m_ovr, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         chk_head("fifo_order_model");
         bus_read(A_DATA, d, s);
         check8("fifo_order_lit", d, bytes[i]);
         rx_pop();
      end
      chk_status("status_drained_ovr");
      bus_write(A_STAT, 8'h04);
      m_ovr = 1'b0;
      chk_status("ovr_cleared");

      send_frame(8'h99, 1'b1);
      send_frame(8'h77, 1'b0);
      chk_status("ferr_status_model");
      bus_read(A_STAT, d, s);
      check8("ferr_status_lit", d, 8'h13);
      chk_head("ferr_keeps_head");
      rx_pop();
      bus_write(A_STAT, 8'h10);
      m_ferr = 1'b0;
      chk_status("ferr_cleared");

      @(negedge clk);
      rxd = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      repeat (60) @(negedge clk);
      chk_status("glitch_rejected");

      bus_read(16'hFF04, d, s);
      check1("sel_outside", s, 1'b0);
      bus_write(16'hFF04, 8'h5A);
      bus_write(16'hFF05, 8'hFF);
      bus_write(16'hFF06, 8'hFF);
      bus_write(16'hFF07, 8'hFF);
      bus_read(A_DIVL, d, s);
      check8("outside_divl", d, 8'h03);
      bus_read(A_DIVH, d, s);
      check8("outside_divh", d, 8'h00);
      chk_status("outside_status");
      repeat (50) @(negedge clk);

      send_frame(8'h42, 1'b1);
      @(negedge clk);
      hold_rx(1'b0, 4);
      hold_rx(1'b1, 4);
      hold_rx(1'b0, 4);
      do_reset();
      repeat (60) @(negedge clk);
      chk_status("rx_reset_status");
      bus_read(A_STAT, d, s);
      check8("rx_reset_status_lit", d, 8'h02);

      set_div3();
      tx_write(8'hC3);
      repeat (18) @(negedge clk);
      do_reset();
      bus_read(A_STAT, d, s);
      check8("tx_reset_status", d, 8'h02);
      bus_read(A_DIVL, d, s);
      check8("tx_reset_divl", d, 8'h67);
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
